// File: rtl/ula_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ula_ctrl_pkg
// Shared definitions for the ULA sequencing controller:
//   - ALU operation codes OP_ADD..OP_NOT (op = {x,y,z} select lines)
//   - controller FSM state encoding
//   - instruction field positions for the default AW=2 build
//     (instr = {op[2:0], rd[1:0], ra[1:0], rb[1:0]}, 9 bits)
// Optional feature macro used by the controller: ULA_CTRL_ZFLAG_EN.
// ---------------------------------------------------------------------------
package ula_ctrl_pkg;

  localparam int DW_DEF = 4;
  localparam int AW_DEF = 2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Instruction field LSB positions; fields are packed MSB first.
  localparam int INSTR_RB_LSB = 0;
  localparam int INSTR_RA_LSB = AW_DEF;
  localparam int INSTR_RD_LSB = 2 * AW_DEF;
  localparam int INSTR_OP_LSB = 3 * AW_DEF;

endpackage

// File: rtl/ula_ctrl_rf.sv
// ---------------------------------------------------------------------------
// ula_ctrl_rf
// 2**AW x DW register file, one synchronous write port, two combinational
// read ports. All entries clear on asynchronous reset.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-high
//   i_we       in   write enable
//   i_waddr    in   write address (AW)
//   i_wdata    in   write data (DW)
//   i_raddr_a  in   read address, port A (AW)
//   i_raddr_b  in   read address, port B (AW)
//   o_rdata_a  out  read data, port A (DW)
//   o_rdata_b  out  read data, port B (DW)
// ---------------------------------------------------------------------------
module ula_ctrl_rf #(
  parameter int DW = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_a,
  output logic [DW-1:0] o_rdata_b
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0] w_mem [NREG];

  // One register per entry so every entry has its own reset and decode.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_ent
      logic [DW-1:0] r_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_q <= '0;
        end else if (i_we && (i_waddr == AW'(gi))) begin
          r_q <= i_wdata;
        end
      end

      assign w_mem[gi] = r_q;
    end
  endgenerate

  assign o_rdata_a = w_mem[i_raddr_a];
  assign o_rdata_b = w_mem[i_raddr_b];

endmodule

// File: rtl/ula_ctrl.sv
// ---------------------------------------------------------------------------
// ula_ctrl
// Sequencing controller for the external 4-bit, 8-op ULA. Accepts a packed
// instruction over valid/ready, drives the ULA operands/selects for one
// cycle (EXEC), writes the ULA result back into the register file, then
// pulses done. One instruction every 3 cycles.
// Optional feature: define ULA_CTRL_ZFLAG_EN to add the registered zero
// flag output zf (alu_s == 0 captured at each writeback).
// Ports:
//   clk, rst           clock (rising) / asynchronous active-high reset
//   in_valid/in_ready  instruction handshake
//   instr              {op[2:0], rd, ra, rb}
//   wr_en/wr_addr/wr_data  direct register load (honoured in IDLE only)
//   alu_a, alu_b       ULA operands (0 outside EXEC)
//   alu_x/alu_y/alu_z  ULA selects = op[2]/op[1]/op[0] (0 outside EXEC)
//   alu_s              ULA result
//   result             last written-back value
//   zf                 zero flag (ULA_CTRL_ZFLAG_EN only)
//   done               one-cycle completion pulse
// ---------------------------------------------------------------------------
module ula_ctrl
  import ula_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3+3*AW-1:0]   instr,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW-1:0]       wr_data,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  output logic                alu_x,
  output logic                alu_y,
  output logic                alu_z,
  input  logic [DW-1:0]       alu_s,
  output logic [DW-1:0]       result,
`ifdef ULA_CTRL_ZFLAG_EN
  output logic                zf,
`endif
  output logic                done
);

  localparam int IW = 3 + 3 * AW;

  state_t        r_state;
  state_t        w_state_next;
  logic [IW-1:0] r_ir;
  logic [DW-1:0] r_result;

  logic [2:0]    w_op;
  logic [AW-1:0] w_rd;
  logic [AW-1:0] w_ra;
  logic [AW-1:0] w_rb;
  logic [DW-1:0] w_rdata_a;
  logic [DW-1:0] w_rdata_b;
  logic          w_accept;
  logic          w_exec;
  logic          w_load;
  logic          w_rf_we;
  logic [AW-1:0] w_rf_waddr;
  logic [DW-1:0] w_rf_wdata;

  assign w_op = r_ir[INSTR_OP_LSB +: 3];
  assign w_rd = r_ir[INSTR_RD_LSB +: AW];
  assign w_ra = r_ir[INSTR_RA_LSB +: AW];
  assign w_rb = r_ir[INSTR_RB_LSB +: AW];

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_exec   = (r_state == EXEC);
  assign w_load   = wr_en && (r_state == IDLE);

  // Writeback and external load never collide: one is EXEC-only, the other
  // IDLE-only. A load coinciding with a handshake lands before EXEC reads.
  assign w_rf_we    = w_exec || w_load;
  assign w_rf_waddr = w_exec ? w_rd  : wr_addr;
  assign w_rf_wdata = w_exec ? alu_s : wr_data;

  ula_ctrl_rf #(
    .DW (DW),
    .AW (AW)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_rf_we),
    .i_waddr   (w_rf_waddr),
    .i_wdata   (w_rf_wdata),
    .i_raddr_a (w_ra),
    .i_raddr_b (w_rb),
    .o_rdata_a (w_rdata_a),
    .o_rdata_b (w_rdata_b)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = EXEC;
      EXEC:    w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output logic: ULA lines are quiet except while executing.
  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    alu_a    = '0;
    alu_b    = '0;
    alu_x    = 1'b0;
    alu_y    = 1'b0;
    alu_z    = 1'b0;
    case (r_state)
      IDLE: in_ready = 1'b1;
      EXEC: begin
        alu_a = w_rdata_a;
        alu_b = w_rdata_b;
        alu_x = w_op[2];
        alu_y = w_op[1];
        alu_z = w_op[0];
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir <= '0;
    end else if (w_accept) begin
      r_ir <= instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
    end else if (w_exec) begin
      r_result <= alu_s;
    end
  end

  assign result = r_result;

`ifdef ULA_CTRL_ZFLAG_EN
  logic r_zf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zf <= 1'b0;
    end else if (w_exec) begin
      r_zf <= (alu_s == '0);
    end
  end

  assign zf = r_zf;
`endif

endmodule

// File: tb/tb_ula_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ula_ctrl
// Directed self-checking bench for ula_ctrl. Contains a behavioural model
// of the external ULA driving alu_s. Build with +define+ULA_CTRL_ZFLAG_EN to
// also cover the zero flag.
// ---------------------------------------------------------------------------
module tb_ula_ctrl;
  import ula_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] instr;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_x;
  logic       alu_y;
  logic       alu_z;
  logic [3:0] alu_s;
  logic [3:0] result;
  logic       done;
`ifdef ULA_CTRL_ZFLAG_EN
  logic       zf;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ula_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr    (instr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_x    (alu_x),
    .alu_y    (alu_y),
    .alu_z    (alu_z),
    .alu_s    (alu_s),
    .result   (result),
`ifdef ULA_CTRL_ZFLAG_EN
    .zf       (zf),
`endif
    .done     (done)
  );

  // Behavioural stand-in for the external combinational ULA.
  always_comb begin
    alu_s = 4'd0;
    case ({alu_x, alu_y, alu_z})
      OP_ADD:  alu_s = alu_a + alu_b;
      OP_SUB:  alu_s = alu_a - alu_b;
      OP_SHL:  alu_s = alu_a << alu_b;
      OP_SHR:  alu_s = alu_a >> alu_b;
      OP_AND:  alu_s = alu_a & alu_b;
      OP_OR:   alu_s = alu_a | alu_b;
      OP_XOR:  alu_s = alu_a ^ alu_b;
      default: alu_s = ~alu_a;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                    input logic [1:0] ra, input logic [1:0] rb);
    return {op, rd, ra, rb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (!in_ready && w < 10) begin
      tick();
      w++;
    end
    chk({tag, ".wait_ready"}, 8'(in_ready), 8'd1);
  endtask

  task automatic load(input logic [1:0] addr, input logic [3:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
    $display("load r%0d = %0d", addr, data);
  endtask

  task automatic issue(input string tag, input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] ra, input logic [1:0] rb,
                       input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] er);
    wait_ready(tag);
    in_valid = 1'b1;
    instr    = mk(op, rd, ra, rb);
    tick();
    in_valid = 1'b0;
    chk({tag, ".alu_a"}, 8'(alu_a), 8'(ea));
    chk({tag, ".alu_b"}, 8'(alu_b), 8'(eb));
    chk({tag, ".sel"}, 8'({alu_x, alu_y, alu_z}), 8'(op));
    chk({tag, ".busy"}, 8'(in_ready), 8'd0);
    tick();
    chk({tag, ".done"}, 8'(done), 8'd1);
    chk({tag, ".result"}, 8'(result), 8'(er));
    tick();
    chk({tag, ".done_off"}, 8'(done), 8'd0);
    chk({tag, ".ready_back"}, 8'(in_ready), 8'd1);
    $display("instr %s op=%0d rd=%0d ra=%0d rb=%0d -> result=%0d (exp %0d)",
             tag, op, rd, ra, rb, result, er);
  endtask

  // Observe a register through a self-OR, which writes back the same value.
  task automatic read_reg(input string tag, input logic [1:0] r, input logic [3:0] exp);
    issue(tag, OP_OR, r, r, r, exp, exp, exp);
  endtask

  logic [5:0] exp_rdy;
  logic [5:0] exp_done;
  int         pulses;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    instr    = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst.in_ready", 8'(in_ready), 8'd1);
    chk("rst.done", 8'(done), 8'd0);
    chk("rst.result", 8'(result), 8'd0);
    chk("rst.alu_a", 8'(alu_a), 8'd0);
    chk("rst.sel", 8'({alu_x, alu_y, alu_z}), 8'd0);
`ifdef ULA_CTRL_ZFLAG_EN
    chk("rst.zf", 8'(zf), 8'd0);
`endif
    $display("reset released");

    // 1: reset while executing drops the instruction
    load(2'd1, 4'd5);
    load(2'd2, 4'd3);
    wait_ready("t1");
    in_valid = 1'b1;
    instr    = mk(OP_ADD, 2'd3, 2'd1, 2'd2);
    tick();
    in_valid = 1'b0;
    chk("t1.exec_a", 8'(alu_a), 8'd5);
    rst = 1'b1;
    #2;
    chk("t1.async_ready", 8'(in_ready), 8'd1);
    chk("t1.async_done", 8'(done), 8'd0);
    tick();
    rst = 1'b0;
    chk("t1.ready", 8'(in_ready), 8'd1);
    chk("t1.result", 8'(result), 8'd0);
    chk("t1.alu_a", 8'(alu_a), 8'd0);
    tick();
    chk("t1.no_done", 8'(done), 8'd0);
    $display("reset mid-EXEC applied");
    read_reg("t1.r1", 2'd1, 4'd0);
    read_reg("t1.r2", 2'd2, 4'd0);
    read_reg("t1.r3", 2'd3, 4'd0);

    // 2: add
    load(2'd1, 4'd5);
    load(2'd2, 4'd3);
    issue("t2.add", OP_ADD, 2'd3, 2'd1, 2'd2, 4'd5, 4'd3, 4'd8);
    read_reg("t2.r3", 2'd3, 4'd8);

    // 3: subtract with wrap, then shift left
    load(2'd1, 4'd3);
    load(2'd2, 4'd5);
    issue("t3.sub", OP_SUB, 2'd0, 2'd1, 2'd2, 4'd3, 4'd5, 4'd14);
    load(2'd2, 4'd2);
    issue("t3.shl", OP_SHL, 2'd0, 2'd1, 2'd2, 4'd3, 4'd2, 4'd12);
    read_reg("t3.r0", 2'd0, 4'd12);

    // 4: back-to-back with in_valid held high
    // rf: r0=12 r1=3 r2=2 r3=8. A: r2 = r0^r3 = 4. B: r3 = r1|r2 = 7.
    exp_rdy  = 6'b100100;
    exp_done = 6'b010010;
    pulses   = 0;
    wait_ready("t4");
    in_valid = 1'b1;
    instr    = mk(OP_XOR, 2'd2, 2'd0, 2'd3);
    tick();
    instr    = mk(OP_OR, 2'd3, 2'd1, 2'd2);
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("t4.ready_c%0d", k), 8'(in_ready), 8'(exp_rdy[k-1]));
      chk($sformatf("t4.done_c%0d", k), 8'(done), 8'(exp_done[k-1]));
      if (done) pulses++;
      if (k == 1) begin
        chk("t4.a_alu_a", 8'(alu_a), 8'd12);
        chk("t4.a_alu_b", 8'(alu_b), 8'd8);
      end
      if (k == 2) chk("t4.a_result", 8'(result), 8'd4);
      if (k == 4) begin
        chk("t4.b_alu_a", 8'(alu_a), 8'd3);
        chk("t4.b_alu_b", 8'(alu_b), 8'd4);
        in_valid = 1'b0;
      end
      if (k == 5) chk("t4.b_result", 8'(result), 8'd7);
      $display("t4 cycle N+%0d ready=%0d done=%0d result=%0d", k, in_ready, done, result);
      tick();
    end
    chk("t4.pulses", 8'(pulses), 8'd2);

    // 5: load coinciding with handshake; loads during EXEC/DONE ignored
    // rf: r0=12 r1=3 r2=4 r3=7
    wait_ready("t5");
    wr_en    = 1'b1;
    wr_addr  = 2'd1;
    wr_data  = 4'd9;
    in_valid = 1'b1;
    instr    = mk(OP_NOT, 2'd0, 2'd1, 2'd2);
    tick();
    in_valid = 1'b0;
    wr_addr  = 2'd2;
    wr_data  = 4'd15;
    chk("t5.alu_a", 8'(alu_a), 8'd9);
    chk("t5.alu_b", 8'(alu_b), 8'd4);
    chk("t5.sel", 8'({alu_x, alu_y, alu_z}), 8'd7);
    tick();
    wr_addr = 2'd3;
    wr_data = 4'd0;
    chk("t5.done", 8'(done), 8'd1);
    chk("t5.result", 8'(result), 8'd6);
    tick();
    wr_en = 1'b0;
    chk("t5.ready", 8'(in_ready), 8'd1);
    $display("instr t5.not with coincident load -> result=%0d (exp 6)", result);
    read_reg("t5.r0", 2'd0, 4'd6);
    read_reg("t5.r1", 2'd1, 4'd9);
    read_reg("t5.r2", 2'd2, 4'd4);
    read_reg("t5.r3", 2'd3, 4'd7);

`ifdef ULA_CTRL_ZFLAG_EN
    // 6: zero flag set by xor-to-zero, cleared by a non-zero writeback
    load(2'd1, 4'd7);
    issue("t6.xor", OP_XOR, 2'd2, 2'd1, 2'd1, 4'd7, 4'd7, 4'd0);
    chk("t6.zf_set", 8'(zf), 8'd1);
    issue("t6.add", OP_ADD, 2'd3, 2'd1, 2'd2, 4'd7, 4'd0, 4'd7);
    chk("t6.zf_clr", 8'(zf), 8'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_ctrl.md
Name: ula_ctrl

Overview:
- Sequencing controller that issues operations to the 4-bit ULA (8-op ALU) and collects its results.
- Holds a small 4-bit register file and accepts packed instructions over a valid/ready handshake.
- Drives the ULA operand and select lines, then writes the ULA result back into the register file.
- Sits between an instruction source (testbench or a future fetch unit) and the existing combinational ALU instance.

Parameters:
- DW, 4, data width; fixed to match the ALU. Any other value is unsupported.
- AW, 2, register address width; register count = 2**AW.
- IW, 3+3*AW (9), instruction width; derived, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  instruction valid.
- in_ready  out  1  controller can accept an instruction.
- instr  in  IW  {op[2:0], rd[AW-1:0], ra[AW-1:0], rb[AW-1:0]}, MSB first.
- wr_en  in  1  direct register load.
- wr_addr  in  AW  load address.
- wr_data  in  DW  load data.
- alu_a  out  DW  ALU operand a.
- alu_b  out  DW  ALU operand b.
- alu_x  out  1  ALU select s2; equals op[2].
- alu_y  out  1  ALU select s1; equals op[1].
- alu_z  out  1  ALU select s0; equals op[0].
- alu_s  in  DW  ALU result.
- result  out  DW  last written-back value.
- done  out  1  one-cycle completion pulse.
- zf  out  1  zero flag; present only with the optional feature.

Behaviour:
- Op encoding (op = {x,y,z}):
  - 000 a+b, 001 a-b, 010 a<<b, 011 a>>b
  - 100 a&b, 101 a|b, 110 a^b, 111 ~a
  - All arithmetic is mod 2**DW, computed by the ALU. The controller never computes the op itself.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch instr into ir and go to EXEC.
  - EXEC: in_ready=0. Combinationally drive alu_a=rf[ir.ra], alu_b=rf[ir.rb], {alu_x,alu_y,alu_z}=ir.op. At the clock edge, capture alu_s into rf[ir.rd] and result; go to DONE.
  - DONE: in_ready=0, done=1 for exactly one cycle, then IDLE.
- Outside EXEC, alu_a, alu_b, alu_x, alu_y and alu_z are 0.
- Latency and throughput:
  - Handshake at edge N → EXEC during cycle N+1 → done high in cycle N+2.
  - One instruction per 3 cycles; in_ready returns high in cycle N+3.
- Register file:
  - Read combinationally.
  - wr_en is honoured only in IDLE and ignored in EXEC/DONE.
  - If wr_en and the handshake coincide in IDLE, the load is applied first. The executing instruction reads the new value, because EXEC reads rf one cycle later.
- Same-register cases: ra==rb and rd==ra are legal. Operands are sampled in EXEC and the write happens at the end of EXEC.
- Op 111 ignores rb for the result; alu_b is still driven with rf[rb].
- in_valid asserted outside IDLE is ignored (not latched). The source holds instr until in_ready.
- Reset (async, any state):
  - state=IDLE; all rf entries, ir and result = 0.
  - done=0; zf=0.
  - An in-flight instruction is dropped with no writeback.
  - in_ready=1 from the first cycle after reset deasserts.

Optional Feature:
- Macro: ULA_CTRL_ZFLAG_EN.
- Defined: port zf exists. zf is registered at the end of EXEC as (alu_s==0) and is held until the next writeback or reset.
- Undefined: port zf and its register are absent; all other behaviour is identical.

Decomposition:
- Package ula_ctrl_pkg holds:
  - op localparams OP_ADD..OP_NOT (3'b000..3'b111)
  - state enum {IDLE, EXEC, DONE}
  - instruction field-slicing constants for AW=2.
- One natural sub-module: ula_ctrl_rf, the 2**AW x DW register file with one write port and two async read ports. Writeback and external load are muxed in the parent.
- The existing ALU is instantiated by the parent level, not inside ula_ctrl.

Test Plan:
1. Reset mid-EXEC → next cycle: state IDLE, in_ready=1, done=0, result=0, rf all 0, no write to rd.
2. Load r1=5, r2=3. Issue op=000, rd=3, ra=1, rb=2 at edge N → alu_a=5, alu_b=3, sel=000 in cycle N+1; done=1 in N+2; result=8; r3=8.
3. r1=3, r2=5. Issue op=001 → r0=14 (wrap). Then op=010 with r1=3, r2=2 → 12.
4. in_valid held high continuously with two instructions → second accepted only in cycle N+3. Exactly two done pulses, 3 cycles apart.
5. wr_en to r1 (=9) in the same IDLE cycle as the handshake of op=111, rd=0, ra=1 → r0=6. Also: wr_en during EXEC is ignored and the rf is unchanged.
6. With ULA_CTRL_ZFLAG_EN: r1=7 xor r1 (op=110) → result=0, zf=1. A following add 7+0 → zf=0.
